// File: rtl/pc_fetch_unit.sv
// Purpose : LEGv8 PC/fetch stage. Holds the PC, fetches over an IMemReq/IMemAck handshake, hands the instruction to decode.
// Latency : instruction visible the cycle after the ack edge; next request issued on the accept edge (no extra bubble).
// Backpress: holds Instruction/Imm26/CurrentPC stable while InstrAccept=0; raises sticky Fault if no ack within TIMEOUT cycles.
//
// Ports:
//   CLK, ResetN                  clock, asynchronous active-low reset
//   IMemReq/IMemAddr             fetch request and address (IMemAddr == CurrentPC)
//   IMemAck/IMemData             memory response strobe and instruction word
//   Instruction/Imm26/InstrValid held instruction, its Imm26 field, and valid flag for decode
//   InstrAccept                  decode/execute retired the held instruction
//   CurrentPC                    PC of the held or in-flight instruction
//   BusImm/Branch/Uncondbranch/Zero  next-PC selection inputs for the held instruction
//   Fault                        sticky fetch-timeout flag
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        ResetN,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic [25:0] Imm26,
    output logic        InstrValid,
    input  logic        InstrAccept,
    output logic [63:0] CurrentPC,
    input  logic [63:0] BusImm,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        Zero,
    output logic        Fault
);

    // ST_START is the request phase before the request flop has come up:
    // reset leaves the fetcher logically in REQ, but IMemReq only rises on
    // the first edge after ResetN deasserts, and no ack is sampled until then.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] timeout_cnt;
    logic [31:0] instr_q;
    logic [63:0] pc_q;
    logic        taken;
    logic [63:0] next_pc;
    logic        ack_seen;
    logic        cnt_expired;

    // Ack only counts while a request is actually outstanding.
    assign ack_seen    = (state == ST_REQ) && IMemAck;
    assign cnt_expired = (timeout_cnt == CNT_LAST);

    // Next-PC selection; both adds wrap modulo 2^64, so a negative BusImm
    // branches backwards and the +4 path wraps from the top of memory to 0.
    assign taken   = Uncondbranch | (Branch & Zero);
    assign next_pc = taken ? (pc_q + BusImm) : (pc_q + 64'd4);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state <= ST_START;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_START: next_state = ST_REQ;
            ST_REQ: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (IMemAck) begin
                    next_state = ST_HOLD;
                end else if (cnt_expired) begin
                    next_state = ST_HALT;
                end
            end
            ST_HOLD: begin
                if (InstrAccept) begin
                    next_state = ST_REQ;
                end
            end
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_START;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        IMemReq    = 1'b0;
        InstrValid = 1'b0;
        Fault      = 1'b0;
        case (state)
            ST_REQ:  IMemReq    = 1'b1;
            ST_HOLD: InstrValid = 1'b1;
            ST_HALT: Fault      = 1'b1;   // sticky: HALT exits only through reset
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: timeout counter, instruction, PC
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            timeout_cnt <= 16'd0;
        end else if (state == ST_REQ && !IMemAck && !cnt_expired) begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end else begin
            timeout_cnt <= 16'd0;
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            instr_q <= 32'h0;
        end else if (ack_seen) begin
            instr_q <= IMemData;
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            pc_q <= RESET_PC;
        end else if (state == ST_HOLD && InstrAccept) begin
            pc_q <= next_pc;
        end
    end

    assign Instruction = instr_q;
    assign Imm26       = instr_q[25:0];
    assign CurrentPC   = pc_q;
    assign IMemAddr    = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_a_n;
    logic        rst_b_n;
    logic        ack;
    logic [31:0] data;
    logic        accept;
    logic [63:0] bus_imm;
    logic        branch;
    logic        uncond;
    logic        zero;

    logic        a_req, a_valid, a_fault;
    logic [63:0] a_addr, a_pc;
    logic [31:0] a_instr;
    logic [25:0] a_imm26;

    logic        b_req, b_valid, b_fault;
    logic [63:0] b_addr, b_pc;
    logic [31:0] b_instr;
    logic [25:0] b_imm26;

    int vectors     = 0;
    int miscompares = 0;

    pc_fetch_unit #(.RESET_PC(64'h100), .TIMEOUT(4)) dut_a (
        .CLK(clk), .ResetN(rst_a_n),
        .IMemReq(a_req), .IMemAddr(a_addr), .IMemAck(ack), .IMemData(data),
        .Instruction(a_instr), .Imm26(a_imm26), .InstrValid(a_valid),
        .InstrAccept(accept), .CurrentPC(a_pc), .BusImm(bus_imm),
        .Branch(branch), .Uncondbranch(uncond), .Zero(zero), .Fault(a_fault)
    );

    pc_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .TIMEOUT(16)) dut_b (
        .CLK(clk), .ResetN(rst_b_n),
        .IMemReq(b_req), .IMemAddr(b_addr), .IMemAck(ack), .IMemData(data),
        .Instruction(b_instr), .Imm26(b_imm26), .InstrValid(b_valid),
        .InstrAccept(accept), .CurrentPC(b_pc), .BusImm(bus_imm),
        .Branch(branch), .Uncondbranch(uncond), .Zero(zero), .Fault(b_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one ack with the given word; leaves the DUT holding it.
    task automatic fetch(input logic [31:0] word);
        ack  = 1'b1;
        data = word;
        tick();
        ack  = 1'b0;
    endtask

    // Retire the held instruction with the given branch controls.
    task automatic retire(input logic u, input logic b, input logic z, input logic [63:0] imm);
        uncond  = u;
        branch  = b;
        zero    = z;
        bus_imm = imm;
        accept  = 1'b1;
        tick();
        uncond  = 1'b0;
        branch  = 1'b0;
        zero    = 1'b0;
        bus_imm = 64'h0;
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ack     = 1'b0;
        data    = 32'h0;
        accept  = 1'b0;
        bus_imm = 64'h0;
        branch  = 1'b0;
        uncond  = 1'b0;
        zero    = 1'b0;

        // ---- reset state ----
        repeat (2) tick();
        chk("rst_req",   64'(a_req),   64'd0);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_fault", 64'(a_fault), 64'd0);
        chk("rst_pc",    a_pc,         64'h100);
        chk("rst_instr", 64'(a_instr), 64'h0);

        // ---- 1: sequential fetch, ack one cycle after request ----
        rst_a_n = 1'b1;
        tick();
        accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_req_on",  64'(a_req),   64'd1);
            chk("seq_addr",    a_addr,       64'h100 + 64'(4 * i));
            chk("seq_val_off", 64'(a_valid), 64'd0);
            fetch(32'hA000_0000 | 32'(i));
            chk("seq_valid",   64'(a_valid), 64'd1);
            chk("seq_req_off", 64'(a_req),   64'd0);
            chk("seq_instr",   64'(a_instr), 64'(32'hA000_0000 | 32'(i)));
            chk("seq_imm26",   64'(a_imm26), 64'(i));
            chk("seq_pc",      a_pc,         64'h100 + 64'(4 * i));
            tick();
            chk("seq_one_cyc", 64'(a_valid), 64'd0);
        end
        chk("seq_addr_end", a_addr, 64'h10C);

        // ---- 2: backward unconditional branch from 0x200 ----
        fetch(32'h1400_0000);
        retire(1'b1, 1'b0, 1'b0, 64'hF4);            // 0x10C -> 0x200
        chk("b_to_200", a_addr, 64'h200);
        fetch(32'h17FF_FFFC);
        chk("b_held_pc", a_pc, 64'h200);
        retire(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("b_back", a_addr, 64'h1F0);
        chk("b_back_req", 64'(a_req), 64'd1);

        // ---- 3: CBZ at 0x300, not taken then taken ----
        fetch(32'h1400_0044);
        retire(1'b1, 1'b0, 1'b0, 64'h110);           // 0x1F0 -> 0x300
        chk("cbz_pc", a_addr, 64'h300);
        fetch(32'hB400_0200);
        retire(1'b0, 1'b1, 1'b0, 64'h40);
        chk("cbz_nt", a_addr, 64'h304);
        fetch(32'h17FF_FFFF);
        retire(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC); // back to 0x300
        chk("cbz_ret", a_addr, 64'h300);
        fetch(32'hB400_0200);
        retire(1'b0, 1'b1, 1'b1, 64'h40);
        chk("cbz_t", a_addr, 64'h340);
        // Both branch flags with Zero=0 still take; BusImm=0 is a self-loop.
        fetch(32'h1400_0000);
        retire(1'b1, 1'b1, 1'b0, 64'h0);
        chk("self_loop", a_addr, 64'h340);

        // ---- 4: decode stall while memory data changes ----
        accept = 1'b0;
        fetch(32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            ack  = 1'b1;
            data = 32'hDEAD_0000 + 32'(i);
            tick();
            chk("stall_instr", 64'(a_instr), 64'h1234_5678);
            chk("stall_imm26", 64'(a_imm26), 64'h234_5678);
            chk("stall_pc",    a_pc,         64'h340);
            chk("stall_req",   64'(a_req),   64'd0);
            chk("stall_valid", 64'(a_valid), 64'd1);
        end
        ack    = 1'b0;
        accept = 1'b1;
        tick();
        chk("stall_rel_req",  64'(a_req), 64'd1);
        chk("stall_rel_addr", a_addr,     64'h344);

        // ---- 5: timeout with TIMEOUT=4 ----
        accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("to_fault_low", 64'(a_fault), 64'd0);
            chk("to_req_high",  64'(a_req),   64'd1);
            tick();
        end
        chk("to_req_4th", 64'(a_req), 64'd1);
        tick();
        chk("to_fault", 64'(a_fault), 64'd1);
        chk("to_req",   64'(a_req),   64'd0);
        chk("to_addr",  a_addr,       64'h344);
        for (int i = 0; i < 20; i++) begin
            ack = i[0];
            tick();
            chk("to_sticky",     64'(a_fault), 64'd1);
            chk("to_req_sticky", 64'(a_req),   64'd0);
            chk("to_val_sticky", 64'(a_valid), 64'd0);
        end
        ack = 1'b0;
        rst_a_n = 1'b0;
        #1;
        chk("to_rst_fault", 64'(a_fault), 64'd0);
        chk("to_rst_pc",    a_pc,         64'h100);
        tick();
        rst_a_n = 1'b1;
        tick();
        chk("to_rst_req",  64'(a_req), 64'd1);
        chk("to_rst_addr", a_addr,     64'h100);
        rst_a_n = 1'b0;

        // ---- 6: async reset mid-REQ, then PC wrap ----
        accept  = 1'b1;
        rst_b_n = 1'b1;
        tick();
        chk("w_req",  64'(b_req), 64'd1);
        chk("w_addr", b_addr,     64'hFFFF_FFFF_FFFF_FFFC);
        ack  = 1'b1;
        data = 32'hCAFE_F00D;
        #3;
        rst_b_n = 1'b0;
        #1;
        chk("ar_req",   64'(b_req),   64'd0);
        chk("ar_valid", 64'(b_valid), 64'd0);
        tick();
        chk("ar_nocap",   64'(b_instr), 64'h0);
        chk("ar_valid2",  64'(b_valid), 64'd0);
        ack = 1'b0;
        rst_b_n = 1'b1;
        tick();
        chk("w_req2", 64'(b_req), 64'd1);
        fetch(32'hD503_201F);
        chk("w_instr", 64'(b_instr), 64'hD503_201F);
        chk("w_valid", 64'(b_valid), 64'd1);
        tick();
        chk("w_wrap", b_pc,       64'h0);
        chk("w_req3", 64'(b_req), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential PC/fetch stage for the single-cycle LEGv8 datapath.
- Holds the program counter and fetches each instruction through a request/acknowledge handshake with instruction memory.
- Presents the instruction, and its Imm26 field for the sign extender, to decode.
- Consumes the 64-bit extended immediate and the branch controls to choose the next PC.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles to wait for IMemAck before raising Fault (range 1..65535).

Ports:
- CLK  input  1  rising-edge clock.
- ResetN  input  1  asynchronous active-low reset.
- IMemReq  output  1  fetch request to instruction memory.
- IMemAddr  output  64  fetch address; equals CurrentPC.
- IMemAck  input  1  memory response valid; sampled only while IMemReq=1.
- IMemData  input  32  instruction word; valid when IMemAck=1.
- Instruction  output  32  captured instruction word.
- Imm26  output  26  Instruction[25:0], the sign-extender input.
- InstrValid  output  1  Instruction/Imm26/CurrentPC are valid for decode.
- InstrAccept  input  1  decode/execute has retired the held instruction.
- CurrentPC  output  64  PC of the held or in-flight instruction.
- BusImm  input  64  extended immediate, already shifted left by 2 for B/CBZ.
- Branch  input  1  conditional branch (CBZ) in the held instruction.
- Uncondbranch  input  1  unconditional branch (B) in the held instruction.
- Zero  input  1  ALU zero flag for the held instruction.
- Fault  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset (ResetN=0, asynchronous):
  - CurrentPC=RESET_PC; Instruction=32'h0; InstrValid=0; IMemReq=0; Fault=0; timeout counter=0; state=REQ.
- Reset mid-fetch abandons any outstanding request. An IMemAck arriving during reset is ignored.
- After ResetN rises, IMemReq asserts on the first CLK edge.
- State REQ (IMemReq=1, InstrValid=0):
  - On an edge with IMemAck=1: Instruction<=IMemData; InstrValid<=1; IMemReq<=0; counter<=0; state<=HOLD.
  - Otherwise counter increments.
  - When the counter reaches TIMEOUT-1 with no ack: Fault<=1 and state<=HALT.
  - Minimum fetch latency is one edge: the instruction is visible the cycle after the ack.
- State HOLD (InstrValid=1, IMemReq=0):
  - Instruction, Imm26 and CurrentPC are stable until InstrAccept=1 is sampled.
  - On the accept edge: CurrentPC<=NextPC; InstrValid<=0; IMemReq<=1; state<=REQ.
  - There is no bubble beyond that one edge.
  - IMemAck is ignored in HOLD.
- State HALT:
  - IMemReq=0; InstrValid=0; Fault=1. CurrentPC holds the faulting address.
  - Only reset exits HALT.
- NextPC (combinational, used only on the accept edge):
  - Taken = Uncondbranch | (Branch & Zero).
  - If Taken: NextPC = CurrentPC + BusImm (64-bit two's complement, modulo 2^64). Negative BusImm branches backwards.
  - Else: NextPC = CurrentPC + 4 (modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
  - If Uncondbranch and Branch are both 1, the branch is taken regardless of Zero.
  - BusImm=0 with Taken gives NextPC=CurrentPC, which is legal (self-loop).
- IMemAddr = CurrentPC at all times.
  - Low two address bits are not checked; a misaligned PC is only reachable via RESET_PC.
- Imm26 = Instruction[25:0] combinationally, so it is valid whenever InstrValid=1.
- IMemAck=1 on the same edge that IMemReq first asserts is not possible: the request is registered, so an ack is only sampled when IMemReq was already 1 before that edge.
- Fault clears only on reset.

Test Plan:
1. Reset with RESET_PC=64'h100; memory acks one cycle after each request; InstrAccept=1 whenever InstrValid=1; no branches.
   - Required: IMemAddr sequence 0x100, 0x104, 0x108.
   - Required: each instruction is held exactly one cycle with InstrValid=1.
2. Held instruction at PC=0x200 with Uncondbranch=1 and BusImm=64'hFFFF_FFFF_FFFF_FFF0 (-16).
   - Required: next IMemAddr=0x1F0.
3. CBZ at PC=0x300 with Branch=1 and BusImm=0x40.
   - With Zero=0: next PC=0x304.
   - Repeat with Zero=1: next PC=0x340.
4. Hold InstrAccept=0 for 5 cycles while IMemData changes.
   - Required: Instruction, Imm26 and CurrentPC are unchanged, IMemReq=0, and the next request occurs only after accept.
5. TIMEOUT=4 with IMemAck never asserted.
   - Required: Fault=1 after 4 REQ cycles, IMemReq drops, and Fault stays at 1 for 20 further cycles.
   - Then pulse ResetN low: Fault=0 and the PC reloads RESET_PC.
6. Drive ResetN low mid-REQ, asynchronously between clock edges, with IMemAck=1.
   - Required: IMemReq and InstrValid fall immediately without waiting for a clock edge, and nothing is captured.
   - Required: with RESET_PC=64'hFFFF_FFFF_FFFF_FFFC and a sequential accept, the PC wraps to 0.
